// File: rtl/eth_tx_frame_gen.sv
// GMII Ethernet TX framer: preamble, SFD, MAC header, streamed payload, zero pad, FCS, inter-frame gap.
// Latency: tx_start accepted at edge N puts the first preamble byte on gmii_txd in cycle N+1; payload bytes drive one cycle after capture.
// Backpressure: s_tready is high only while payload is being pulled (plus one prefetch cycle) and while draining; a missing byte aborts the frame.
//
// Ports:
//   aclk, aresetn          GMII TX clock, synchronous active-low reset
//   tx_start               frame request, honoured only when idle
//   mac_d_addr/mac_s_addr  destination/source MAC, latched at accept, MSB byte first on the wire
//   ethertype              EtherType/length, latched at accept, MSB byte first
//   s_tdata/s_tvalid/s_tlast/s_tready  payload byte stream
//   gmii_txd/gmii_tx_en/gmii_tx_er     registered GMII transmit pins
//   tx_busy                high whenever the FSM is not idle
//   tx_frame_done          pulse with the last FCS byte
//   tx_err                 pulse with the abort (underrun/oversize) error cycle
module eth_tx_frame_gen #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        tx_start,
    input  logic [47:0] mac_d_addr,
    input  logic [47:0] mac_s_addr,
    input  logic [15:0] ethertype,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic        tx_frame_done,
    output logic        tx_err
);

    localparam logic [10:0] MIN_P   = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P   = 11'(MAX_PAYLOAD);
    localparam logic [7:0]  PRE_L   = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_L   = 8'(IFG_CYCLES - 1);
    localparam logic [7:0]  HDR_END = 8'd13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } state_t;

    state_t       state;
    logic [111:0] hdr_sh;     // DA, SA, EtherType; top byte is the next one on the wire
    logic [31:0]  crc;
    logic [10:0]  byte_cnt;   // payload + pad bytes sent so far
    logic [7:0]   gen_cnt;    // preamble / header / FCS / IFG position
    logic [31:0]  fcs_word;
    logic [7:0]   fcs_byte;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        fcs_word = ~crc;
        fcs_byte = fcs_word[7:0];
        case (gen_cnt[1:0])
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            2'd3:    fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    assign tx_busy = (state != ST_IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            hdr_sh        <= '0;
            crc           <= 32'hFFFFFFFF;
            byte_cnt      <= '0;
            gen_cnt       <= '0;
            s_tready      <= 1'b0;
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            tx_frame_done <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            // Per-cycle defaults: pins idle, pulses low; each state overrides.
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            tx_frame_done <= 1'b0;
            tx_err        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    s_tready <= 1'b0;
                    if (tx_start) begin
                        hdr_sh     <= {mac_d_addr, mac_s_addr, ethertype};
                        gmii_txd   <= 8'h55;
                        gmii_tx_en <= 1'b1;
                        gen_cnt    <= 8'd1;
                        byte_cnt   <= '0;
                        crc        <= 32'hFFFFFFFF;
                        state      <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    gmii_tx_en <= 1'b1;
                    if (gen_cnt < PRE_L) begin
                        gmii_txd <= 8'h55;
                        gen_cnt  <= gen_cnt + 8'd1;
                    end else begin
                        gmii_txd <= 8'hD5;
                        gen_cnt  <= '0;
                        crc      <= 32'hFFFFFFFF;
                        state    <= ST_SFD;
                    end
                end

                // The SFD cycle issues header byte 0, so both states share this path.
                ST_SFD, ST_HEADER: begin
                    gmii_txd   <= hdr_sh[111:104];
                    gmii_tx_en <= 1'b1;
                    crc        <= crc_step(crc, hdr_sh[111:104]);
                    hdr_sh     <= {hdr_sh[103:0], 8'h00};
                    gen_cnt    <= gen_cnt + 8'd1;
                    state      <= ST_HEADER;
                    if (gen_cnt == HDR_END) begin
                        // Raise ready alongside the last header byte so payload
                        // byte 0 is captured in time to follow it directly.
                        s_tready <= 1'b1;
                        byte_cnt <= '0;
                        state    <= ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    if (!s_tvalid || byte_cnt == MAX_P) begin
                        // Abort: one error cycle on the wire, then discard the
                        // rest of the stream. The offending byte (if any) is
                        // consumed by this handshake.
                        gmii_txd   <= 8'h00;
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= 1'b1;
                        tx_err     <= 1'b1;
                        if (byte_cnt == MAX_P) byte_cnt <= MAX_P + 11'd1;
                        if (s_tvalid && s_tlast) begin
                            s_tready <= 1'b0;
                            gen_cnt  <= '0;
                            state    <= ST_IFG;
                        end else begin
                            s_tready <= 1'b1;
                            state    <= ST_DRAIN;
                        end
                    end else begin
                        gmii_txd   <= s_tdata;
                        gmii_tx_en <= 1'b1;
                        crc        <= crc_step(crc, s_tdata);
                        byte_cnt   <= byte_cnt + 11'd1;
                        if (s_tlast) begin
                            s_tready <= 1'b0;
                            gen_cnt  <= '0;
                            state    <= (byte_cnt + 11'd1 < MIN_P) ? ST_PAD : ST_FCS;
                        end
                    end
                end

                ST_PAD: begin
                    gmii_tx_en <= 1'b1;
                    crc        <= crc_step(crc, 8'h00);
                    byte_cnt   <= byte_cnt + 11'd1;
                    if (byte_cnt + 11'd1 == MIN_P) state <= ST_FCS;
                end

                ST_FCS: begin
                    gmii_txd   <= fcs_byte;
                    gmii_tx_en <= 1'b1;
                    gen_cnt    <= gen_cnt + 8'd1;
                    if (gen_cnt[1:0] == 2'd3) begin
                        tx_frame_done <= 1'b1;
                        gen_cnt       <= '0;
                        state         <= ST_IFG;
                    end
                end

                // Entered on the edge that drives the final wire byte, so the
                // last count leaves exactly IFG_CYCLES idle cycles before the
                // next tx_start can be sampled in IDLE.
                ST_IFG: begin
                    s_tready <= 1'b0;
                    if (gen_cnt >= IFG_L) state <= ST_IDLE;
                    else                  gen_cnt <= gen_cnt + 8'd1;
                end

                ST_DRAIN: begin
                    s_tready <= 1'b1;
                    if (s_tvalid && s_tlast) begin
                        s_tready <= 1'b0;
                        gen_cnt  <= '0;
                        state    <= ST_IFG;
                    end
                end

                default: begin
                    s_tready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
